mdu_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer beside the ALU in the execute stage. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request at a time over a valid/ready handshake. It computes the result with a shift-add multiplier or a restoring divider over 32 iterations, then holds the result until the pipeline consumes it. The pipeline stalls on `busy` while an operation is in flight.

---
 rtl/mdu_seq.sv | 202 ++++++++++++++++++++
 tb/tb_mdu_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer.
// One request at a time: shift-add multiply or restoring divide over WIDTH
// steps, sign fix-up, then the result is held until the consumer takes it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; req_ready high
// PREP  | record signs, take magnitudes, load counter, catch special cases
// ITER  | one multiply/divide step per cycle, counter WIDTH-1 down to 0
// FIX   | apply sign, select output field, register result
// DONE  | resp_valid presented (one cycle after entry) until resp_ready
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = 6;
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 resp_valid_q, resp_valid_d;

  // operation decode from the latched funct3
  logic is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_div   = op_q[2];
  assign is_rem   = op_q[2] & op_q[1];
  assign a_signed = (op_q == 3'b001) | (op_q == 3'b010) | (op_q == 3'b100) | (op_q == 3'b110);
  assign b_signed = (op_q == 3'b001) | (op_q == 3'b100) | (op_q == 3'b110);
  assign a_neg    = a_signed & a_q[WIDTH-1];
  assign b_neg    = b_signed & b_q[WIDTH-1];
  assign a_mag    = a_neg ? -a_q : a_q;
  assign b_mag    = b_neg ? -b_q : b_q;

  // Multiply step: acc = {hi, lo}; lo starts as the multiplier, hi as 0.
  // The add keeps its carry, which becomes the MSB after the right shift.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: acc = {remainder, quotient}; quotient half starts as the
  // dividend and fills with quotient bits from the right.
  logic [WIDTH:0]       div_sh;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, b_q});
  assign div_diff = div_sh[WIDTH-1:0] - b_q;
  assign div_next = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

  // Sign fix-up and output field selection
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix, fix_val;
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // pick the result field for the latched operation
  always_comb begin
    fix_val = prod_fix[WIDTH-1:0];
    case (op_q)
      3'b000:                 fix_val = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_val = quot_fix;
      default:                fix_val = rem_fix;
    endcase
  end

  // next-state and datapath updates; flush overrides everything
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    neg_res_d    = neg_res_q;
    neg_rem_d    = neg_rem_q;
    result_d     = result_q;
    resp_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          op_d    = funct;
          a_d     = A;
          b_d     = B;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        cnt_d     = CNT_LOAD;
        neg_res_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        b_d       = b_mag;
        acc_d     = {{WIDTH{1'b0}}, a_mag};
        if (is_div && (b_q == '0)) begin
          result_d = is_rem ? a_q : '1;
          state_d  = S_DONE;
        end else if (is_div && a_signed && (a_q == INT_MIN) && (b_q == '1)) begin
          result_d = is_rem ? '0 : INT_MIN;
          state_d  = S_DONE;
        end else begin
          state_d  = S_ITER;
        end
      end
      S_ITER: begin
        acc_d = is_div ? div_next : mul_next;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_FIX: begin
        result_d = fix_val;
        state_d  = S_DONE;
      end
      S_DONE: begin
        // resp_valid follows DONE entry by one cycle, so the handshake is
        // only honoured once the result is actually being presented
        if (resp_valid_q && resp_ready) begin
          state_d = S_IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d      = S_IDLE;
      resp_valid_d = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      neg_res_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      neg_res_q    <= neg_res_d;
      neg_rem_q    <= neg_rem_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign result     = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: a timeline model of the unit (accept, fixed
// latency, hold until handshake) plus an arithmetic reference for RV32M.
module tb_mdu_seq;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct;
  logic [31:0] A, B;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mdu_seq #(.WIDTH(32)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .funct      (funct),
    .A          (A),
    .B          (B),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .busy       (busy)
  );

  always #5 Clock = ~Clock;

  // RV32M reference computed with wide integer arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Timeline model: idle -> waiting N edges -> valid until taken.
  bit          m_idle  = 1'b1;
  bit          m_valid = 1'b0;
  int          m_wait  = 0;
  logic [31:0] m_exp   = '0;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      m_idle  = 1'b1;
      m_valid = 1'b0;
      m_wait  = 0;
    end else if (flush) begin
      m_idle  = 1'b1;
      m_valid = 1'b0;
      m_wait  = 0;
    end else if (m_idle) begin
      if (req_valid) begin
        m_idle  = 1'b0;
        m_exp   = ref_mdu(funct, A, B);
        m_wait  = is_special(funct, A, B) ? 2 : 35;
      end
    end else if (m_valid) begin
      if (resp_ready) begin
        m_idle  = 1'b1;
        m_valid = 1'b0;
      end
    end else begin
      m_wait = m_wait - 1;
      if (m_wait == 0) m_valid = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // advance one cycle and compare every observable output to the model
  task automatic tick();
    @(negedge Clock);
    check("req_ready", {31'd0, req_ready}, {31'd0, m_idle});
    check("busy", {31'd0, busy}, {31'd0, !m_idle});
    check("resp_valid", {31'd0, resp_valid}, {31'd0, m_valid});
    if (m_valid) check("result", result, m_exp);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    int          lat;
  } vec_t;

  vec_t vecs[21];

  task automatic run_op(input int idx);
    vec_t v;
    int n;
    v = vecs[idx];
    check("model_pin", ref_mdu(v.f, v.a, v.b), v.e);
    funct     = v.f;
    A         = v.a;
    B         = v.b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    funct     = 3'($urandom);
    A         = ~v.a;
    B         = $urandom;
    n = 0;
    while (!resp_valid && n < 100) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(v.lat));
    check("lit_result", result, v.e);
    if (resp_ready) tick();
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 35};
    vecs[4]  = '{3'd5, 32'd100,       32'd7,         32'd14,        35};
    vecs[5]  = '{3'd7, 32'd100,       32'd7,         32'd2,         35};
    vecs[6]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35};
    vecs[7]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35};
    vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 2};
    vecs[9]  = '{3'd7, 32'h0000_1234, 32'd0,         32'h0000_1234, 2};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2};
    vecs[12] = '{3'd4, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        35};
    vecs[13] = '{3'd6, 32'd100,       32'hFFFF_FFF9, 32'd2,         35};
    vecs[14] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         35};
    vecs[15] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35};
    vecs[16] = '{3'd3, 32'h8000_0000, 32'd2,         32'd1,         35};
    vecs[17] = '{3'd5, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 2};
    vecs[18] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 2};
    vecs[19] = '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'd0,         35};
    vecs[20] = '{3'd1, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 35};

    Reset_n    = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    funct      = '0;
    A          = '0;
    B          = '0;
    #3;
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    tick();
    #2 Reset_n = 1'b1;
    tick();

    for (int i = 0; i < 21; i++) run_op(i);

    // backpressure: result held, requests refused while waiting
    resp_ready = 1'b0;
    run_op(4);
    for (int k = 0; k < 10; k++) begin
      funct     = 3'd0;
      A         = 32'd3;
      B         = 32'd5;
      req_valid = 1'b1;
      tick();
      check("bp_result", result, 32'd14);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    check("bp_release_idle", {31'd0, req_ready}, 32'd1);
    check("bp_release_valid", {31'd0, resp_valid}, 32'd0);
    tick();

    // flush mid-iteration together with a fresh request
    funct     = 3'd5;
    A         = 32'd1000;
    B         = 32'd3;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (9) tick();
    flush     = 1'b1;
    req_valid = 1'b1;
    funct     = 3'd0;
    A         = 32'd2;
    B         = 32'd2;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush_idle", {31'd0, req_ready}, 32'd1);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_valid", {31'd0, resp_valid}, 32'd0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (resp_valid) seen++;
      end
      check("flush_no_resp", 32'(seen), 32'd0);
    end

    // asynchronous reset in the middle of an operation
    funct     = 3'd1;
    A         = 32'h1234_5678;
    B         = 32'h0000_0100;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    #2 Reset_n = 1'b0;
    #1;
    check("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_req_ready", {31'd0, req_ready}, 32'd1);
    tick();
    #2 Reset_n = 1'b1;
    tick();

    // unit still works after reset
    run_op(5);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
